// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and operand-decode helpers for the multiply/divide unit.
package ex_muldiv_pkg;

  // funct3 encodings of the M-extension instructions
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // All divide/remainder ops have funct3[2] set
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic op_src1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is signed for MULH, DIV, REM (MULHSU keeps rs2 unsigned)
  function automatic logic op_src2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle. The next quotient/remainder are exposed combinationally so the
// parent can register the sign-fixed result on the final iteration edge.
module ex_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic            busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // One restoring step: shift in the next dividend bit and try to subtract
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    rem_nxt_o = shifted[XLEN-1:0];
    quo_nxt_o = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_nxt_o = diff[XLEN-1:0];
      quo_nxt_o = {quo_q[XLEN-2:0], 1'b1};
    end
    last_o = busy_q && (cnt_q == CNT_W'(XLEN - 1));
  end

  // Iteration counter and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
      if (last_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M execute unit: shift-add multiplier, restoring
// divider (ex_div_core) and valid/ready handshakes on both sides.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | ready_o=1, waiting for a request
// MD_CALC | iterating multiply or divide, requests stalled upstream
// MD_DONE | valid_o=1, result held until downstream takes it
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_BITS   = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       src1_i,
  input  logic [XLEN-1:0]       src2_i,
  input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] w_reg_addr_o,
  output logic                  ex_w_reg_enable_o
);

  localparam int MUL_ITER = XLEN / MUL_BITS;
  localparam int CNT_W    = $clog2(XLEN);

  md_state_e               state_q, state_d;
  md_op_e                  op_q;
  logic [REG_ADDR_W-1:0]   waddr_q;
  logic                    sign1_q, sign2_q;
  logic [XLEN-1:0]         mcand_q;
  logic [2*XLEN-1:0]       acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [XLEN-1:0]         result_q;

  logic                    accept;
  logic                    sign1, sign2;
  logic [XLEN-1:0]         mag1, mag2;
  logic                    div_zero, div_ovf, special;
  logic [XLEN-1:0]         special_res;

  logic [XLEN+MUL_BITS-1:0] mul_pp, mul_sum;
  logic [2*XLEN-1:0]       acc_nxt, prod;
  logic                    mul_last;
  logic [XLEN-1:0]         mul_res;

  logic                    div_start, div_last;
  logic [XLEN-1:0]         quo_nxt, rem_nxt, div_res;

  // Request decode: sign flags, magnitudes and divide corner cases
  always_comb begin
    accept   = (state_q == MD_IDLE) && valid_i && !flush_i;
    sign1    = op_src1_signed(op_i) && src1_i[XLEN-1];
    sign2    = op_src2_signed(op_i) && src2_i[XLEN-1];
    mag1     = sign1 ? -src1_i : src1_i;
    mag2     = sign2 ? -src2_i : src2_i;
    div_zero = op_is_div(op_i) && (src2_i == '0);
    div_ovf  = ((op_i == MD_DIV) || (op_i == MD_REM)) &&
               (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
    special  = div_zero || div_ovf;
    // op_i[1] separates REM/REMU from DIV/DIVU
    special_res = '0;
    if (div_zero)     special_res = op_i[1] ? src1_i : '1;
    else if (div_ovf) special_res = op_i[1] ? '0 : src1_i;
    div_start = accept && op_is_div(op_i) && !special;
  end

  // Multiplier step: add mcand*digit to the high half, shift right MUL_BITS
  always_comb begin
    mul_pp   = {{MUL_BITS{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
    mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
    acc_nxt  = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
    prod     = (sign1_q ^ sign2_q) ? -acc_nxt : acc_nxt;
    mul_res  = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    mul_last = (state_q == MD_CALC) && !op_is_div(op_q) &&
               (cnt_q == CNT_W'(MUL_ITER - 1));
  end

  ex_div_core #(.XLEN(XLEN)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .start_i    (div_start),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .last_o     (div_last),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Divide sign fix: quotient takes sign1^sign2, remainder takes sign1
  always_comb begin
    if (op_q[1]) div_res = sign1_q ? -rem_nxt : rem_nxt;
    else         div_res = (sign1_q ^ sign2_q) ? -quo_nxt : quo_nxt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Next state; flush wins over accept and over the result handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (flush_i)                   state_d = MD_IDLE;
        else if (mul_last || div_last) state_d = MD_DONE;
      end
      MD_DONE: if (flush_i || ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Operand latch at accept, multiplier iteration and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MD_MUL;
      waddr_q  <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= md_op_e'(op_i);
      waddr_q <= w_reg_addr_i;
      sign1_q <= sign1;
      sign2_q <= sign2;
      mcand_q <= mag1;
      acc_q   <= {{XLEN{1'b0}}, mag2};
      cnt_q   <= '0;
      if (special) result_q <= special_res;
    end else if ((state_q == MD_CALC) && !flush_i) begin
      if (op_is_div(op_q)) begin
        if (div_last) result_q <= div_res;
      end else begin
        acc_q <= acc_nxt;
        if (mul_last) begin
          result_q <= mul_res;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign ready_o           = (state_q == MD_IDLE);
  assign valid_o           = (state_q == MD_DONE);
  assign result_o          = result_q;
  assign w_reg_addr_o      = waddr_q;
  assign ex_w_reg_enable_o = valid_o && (waddr_q != '0);

endmodule
